// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
//  Module   : wb_unit
//  Purpose  : Writeback unit. Sole writer of the register file write port.
//             Merges single-cycle ALU results and buffered LSU results into
//             one registered write stream. Keeps a per-register busy
//             scoreboard that stalls issue on RAW/WAW hazards.
//  Options  : WB_LSU_BYPASS_EN - when defined, a lone LSU result (FIFO empty,
//             no ALU result) skips the FIFO and is written one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_unit #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    // issue side
    input  logic             i_iss_valid,
    input  logic [AW-1:0]    i_iss_rs1,
    input  logic [AW-1:0]    i_iss_rs2,
    input  logic [AW-1:0]    i_iss_rd,
    input  logic             i_iss_rd_we,
    output logic             o_iss_ready,
    // ALU result (never backpressured)
    input  logic             i_alu_valid,
    input  logic [AW-1:0]    i_alu_rd,
    input  logic [WIDTH-1:0] i_alu_data,
    // LSU result
    input  logic             i_lsu_valid,
    output logic             o_lsu_ready,
    input  logic [AW-1:0]    i_lsu_rd,
    input  logic [WIDTH-1:0] i_lsu_data,
    // register file write port
    output logic             o_wr_en,
    output logic [AW-1:0]    o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data,
    // number of busy registers
    output logic [AW:0]      o_pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] c_full_cnt = FIFO_DEPTH[PW:0];

    // scoreboard and write port state
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_pending;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;

    // LSU result FIFO
    logic [AW-1:0]    r_fifo_rd   [FIFO_DEPTH];
    logic [WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_iss_fire;
    logic             w_win_valid;
    logic [AW-1:0]    w_win_rd;
    logic [WIDTH-1:0] w_win_data;
    logic [DEPTH-1:0] w_busy_next;
    logic [AW:0]      w_pending_next;

    assign w_fifo_full  = (r_count == c_full_cnt);
    assign w_fifo_empty = (r_count == '0);
    assign o_lsu_ready  = !w_fifo_full;

    // busy[0] is held at zero, so x0 sources and destinations never stall
    assign o_iss_ready = !(r_busy[i_iss_rs1] | r_busy[i_iss_rs2] |
                           (i_iss_rd_we & r_busy[i_iss_rd])) & !w_fifo_full;
    assign w_iss_fire  = i_iss_valid & o_iss_ready;

`ifdef WB_LSU_BYPASS_EN
    assign w_bypass = !i_alu_valid & w_fifo_empty & i_lsu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // a bypassed LSU result goes straight to the write port instead of the FIFO
    assign w_push = i_lsu_valid & o_lsu_ready & !w_bypass;

    // fixed-priority winner select: ALU, then FIFO head, then bypassed LSU
    always_comb begin
        w_win_valid = 1'b0;
        w_win_rd    = '0;
        w_win_data  = '0;
        w_pop       = 1'b0;
        if (i_alu_valid) begin
            w_win_valid = 1'b1;
            w_win_rd    = i_alu_rd;
            w_win_data  = i_alu_data;
        end else if (!w_fifo_empty) begin
            w_win_valid = 1'b1;
            w_win_rd    = r_fifo_rd[r_rptr];
            w_win_data  = r_fifo_data[r_rptr];
            w_pop       = 1'b1;
        end else if (w_bypass) begin
            w_win_valid = 1'b1;
            w_win_rd    = i_lsu_rd;
            w_win_data  = i_lsu_data;
        end
    end

    // next busy vector: writeback clears, issue sets, set applied last so it wins
    always_comb begin
        w_busy_next = r_busy;
        if (w_win_valid) begin
            w_busy_next[w_win_rd] = 1'b0;
        end
        if (w_iss_fire && i_iss_rd_we && (i_iss_rd != '0)) begin
            w_busy_next[i_iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // popcount of the next busy vector so o_pending tracks r_busy exactly
    always_comb begin
        w_pending_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pending_next = w_pending_next + {{AW{1'b0}}, w_busy_next[i]};
        end
    end

    // scoreboard, write port and FIFO pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_pending <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_busy    <= w_busy_next;
            r_pending <= w_pending_next;
            r_wr_en   <= w_win_valid && (w_win_rd != '0);
            if (w_win_valid) begin
                r_wr_addr <= w_win_rd;
                r_wr_data <= w_win_data;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= i_lsu_rd;
            r_fifo_data[r_wptr] <= i_lsu_data;
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_unit
//  Purpose  : Self-checking bench for wb_unit. Expected register file writes
//             are queued when results are driven and compared as they appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int AW = 5;
`ifdef WB_LSU_BYPASS_EN
    localparam int c_lsu_lat = 1;
`else
    localparam int c_lsu_lat = 2;
`endif

    logic             clk;
    logic             rst;
    logic             i_iss_valid;
    logic [AW-1:0]    i_iss_rs1;
    logic [AW-1:0]    i_iss_rs2;
    logic [AW-1:0]    i_iss_rd;
    logic             i_iss_rd_we;
    logic             o_iss_ready;
    logic             i_alu_valid;
    logic [AW-1:0]    i_alu_rd;
    logic [WIDTH-1:0] i_alu_data;
    logic             i_lsu_valid;
    logic             o_lsu_ready;
    logic [AW-1:0]    i_lsu_rd;
    logic [WIDTH-1:0] i_lsu_data;
    logic             o_wr_en;
    logic [AW-1:0]    o_wr_addr;
    logic [WIDTH-1:0] o_wr_data;
    logic [AW:0]      o_pending;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  cycles;

    wb_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_iss_valid(i_iss_valid), .i_iss_rs1(i_iss_rs1), .i_iss_rs2(i_iss_rs2),
        .i_iss_rd(i_iss_rd), .i_iss_rd_we(i_iss_rd_we), .o_iss_ready(o_iss_ready),
        .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
        .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_pending(o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // single-cycle issue of an instruction that is expected to fire
    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we);
        i_iss_valid = 1'b1;
        i_iss_rs1   = rs1;
        i_iss_rs2   = rs2;
        i_iss_rd    = rd;
        i_iss_rd_we = we;
        #1;
        check("issue_ready", o_iss_ready, 1);
        step();
        i_iss_valid = 1'b0;
    endtask

    // scoreboard: every write leaving the DUT must match the head of the queue
    always @(negedge clk) begin
        if (!rst && o_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {59'd0, o_wr_addr}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {59'd0, o_wr_addr}, {59'd0, mon_e.addr});
                check("wr_data", {32'd0, o_wr_data}, {32'd0, mon_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        i_iss_valid = 0; i_iss_rs1 = 0; i_iss_rs2 = 0; i_iss_rd = 0; i_iss_rd_we = 0;
        i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
        i_lsu_valid = 0; i_lsu_rd = 0; i_lsu_data = 0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_pending", o_pending, 0);
        check("rst_lsu_ready", o_lsu_ready, 1);
        i_iss_valid = 1'b1;
        #1;
        check("rst_iss_ready", o_iss_ready, 1);
        i_iss_valid = 1'b0;
        step();

        // RAW stall on x5 until the ALU writes it back
        issue(0, 0, 5, 1);
        check("raw_pending", o_pending, 1);
        i_iss_valid = 1; i_iss_rs1 = 5; i_iss_rs2 = 0; i_iss_rd = 6; i_iss_rd_we = 1;
        #1;
        check("raw_stall0", o_iss_ready, 0);
        step();
        check("raw_stall1", o_iss_ready, 0);
        push_exp(5, 32'hDEADBEEF);
        i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 32'hDEADBEEF;
        step();
        i_alu_valid = 0;
        check("raw_wr_en", o_wr_en, 1);
        check("raw_wr_addr", o_wr_addr, 5);
        check("raw_wr_data", o_wr_data, 32'hDEADBEEF);
        check("raw_release", o_iss_ready, 1);
        i_iss_valid = 0;
        check("raw_pending_clr", o_pending, 0);
        step();

        // ALU and LSU in the same cycle: ALU first, LSU next
        issue(0, 0, 3, 1);
        issue(0, 0, 7, 1);
        check("prio_pending2", o_pending, 2);
        push_exp(3, 32'h0000_AAAA);
        push_exp(7, 32'h0000_BBBB);
        i_alu_valid = 1; i_alu_rd = 3; i_alu_data = 32'h0000_AAAA;
        i_lsu_valid = 1; i_lsu_rd = 7; i_lsu_data = 32'h0000_BBBB;
        step();
        i_alu_valid = 0; i_lsu_valid = 0;
        check("prio_addr_first", o_wr_addr, 3);
        check("prio_pending1", o_pending, 1);
        step();
        check("prio_wr_en_second", o_wr_en, 1);
        check("prio_addr_second", o_wr_addr, 7);
        check("prio_pending0", o_pending, 0);
        step();
        check("prio_idle", o_wr_en, 0);

        // ALU holds the FIFO for 6 cycles while the LSU fills it
        for (int i = 0; i < 6; i++) push_exp(AW'(10 + i), 32'hA000 + i);
        for (int i = 0; i < 4; i++) push_exp(AW'(20 + i), 32'hB000 + i);
        for (int i = 0; i < 6; i++) begin
            i_alu_valid = 1; i_alu_rd = AW'(10 + i); i_alu_data = 32'hA000 + i;
            i_lsu_valid = (i < 4); i_lsu_rd = AW'(20 + i); i_lsu_data = 32'hB000 + i;
            step();
            if (i == 3) begin
                check("full_lsu_ready", o_lsu_ready, 0);
                i_iss_valid = 1; i_iss_rs1 = 0; i_iss_rs2 = 0; i_iss_rd = 0; i_iss_rd_we = 0;
                #1;
                check("full_iss_ready", o_iss_ready, 0);
                i_iss_valid = 0;
            end
        end
        i_alu_valid = 0; i_lsu_valid = 0;
        check("full_still_blocked", o_lsu_ready, 0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("fifo_drain", exp_q.size(), 0);
        check("drain_lsu_ready", o_lsu_ready, 1);

        // rd=0 ALU result: no write, busy untouched
        issue(0, 0, 9, 1);
        i_alu_valid = 1; i_alu_rd = 0; i_alu_data = 32'h1234;
        step();
        i_alu_valid = 0;
        check("x0_wr_en", o_wr_en, 0);
        check("x0_pending", o_pending, 1);
        push_exp(9, 32'h9999);
        i_alu_valid = 1; i_alu_rd = 9; i_alu_data = 32'h9999;
        step();
        i_alu_valid = 0;
        check("x9_pending_clr", o_pending, 0);
        step();

        // reset with three LSU entries queued behind the ALU
        issue(0, 0, 11, 1);
        issue(0, 0, 12, 1);
        issue(0, 0, 13, 1);
        check("mid_pending3", o_pending, 3);
        for (int i = 0; i < 3; i++) begin
            i_alu_valid = 1; i_alu_rd = 0; i_alu_data = 32'h55;
            i_lsu_valid = 1; i_lsu_rd = AW'(11 + i); i_lsu_data = 32'hC000 + i;
            step();
        end
        i_alu_valid = 0; i_lsu_valid = 0;
        rst = 1'b1;
        #1;
        check("mid_rst_pending", o_pending, 0);
        check("mid_rst_wr_en", o_wr_en, 0);
        check("mid_rst_lsu_ready", o_lsu_ready, 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_no_write", o_wr_en, 0);
        end

        // lone LSU result latency
        push_exp(14, 32'hC0DE);
        i_lsu_valid = 1; i_lsu_rd = 14; i_lsu_data = 32'hC0DE;
        step();
        i_lsu_valid = 0;
        cycles = 1;
        while (!o_wr_en && cycles < 6) begin
            step();
            cycles++;
        end
        check("lsu_latency", cycles, c_lsu_lat);
        repeat (3) step();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
